// File: rtl/bcd_conv_sched.sv
// Two-requester binary-to-BCD converter (double-dabble, one bit per clock).
// Define BCD_RR_ARB_EN for round-robin arbitration; otherwise req0 has fixed priority.
module bcd_conv_sched #(
  parameter int BIN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [BIN_W-1:0] bin0,
  input  logic             req1,
  input  logic [BIN_W-1:0] bin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [15:0]      bcd
);

  localparam int SW = 16 + BIN_W;
  localparam logic [3:0] LAST = 4'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] shift, shift_step;
  logic [3:0]    cnt;
  logic          cur_id;
  logic          any_req;
  logic          win;

  // Correct every BCD nibble that would overflow on doubling, then shift left.
  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int k = 0; k < 4; k++) begin
      if (t[BIN_W+4*k +: 4] >= 4'd5)
        t[BIN_W+4*k +: 4] = t[BIN_W+4*k +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  assign any_req    = req0 | req1;
  assign shift_step = dabble(shift);
  assign busy       = (state != IDLE);

`ifdef BCD_RR_ARB_EN
  // ptr names the requester preferred on a tie: the one not served last.
  logic ptr;

  assign win = (req0 && req1) ? ptr : ~req0;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (state == IDLE && any_req)
      ptr <= ~win;
  end
`else
  assign win = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift   <= '0;
      cnt     <= 4'd0;
      cur_id  <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      bcd     <= 16'h0000;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            shift  <= {16'h0000, (win ? bin1 : bin0)};
            cnt    <= 4'd0;
            cur_id <= win;
            gnt0   <= ~win;
            gnt1   <= win;
          end
        end
        SHIFT: begin
          shift <= shift_step;
          cnt   <= cnt + 4'd1;
          // The final iteration's result goes straight to the output register.
          if (cnt == LAST) begin
            bcd     <= shift_step[SW-1:BIN_W];
            done_id <= cur_id;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 SHALL have parameter: BIN_W, default 12, binary input width (legal 4..13); internal shift register width = 16+BIN_W.
REQ-002 SHALL have port: clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req0  input  1  requester 0 conversion request, level.
REQ-005 SHALL have port: bin0  input  BIN_W  requester 0 binary operand.
REQ-006 SHALL have port: req1  input  1  requester 1 conversion request, level.
REQ-007 SHALL have port: bin1  input  BIN_W  requester 1 binary operand.
REQ-008 SHALL have port: gnt0 / gnt1  output  1 each  one-cycle grant pulse; operand captured.
REQ-009 SHALL have port: busy  output  1  high while a conversion is in progress or completing.
REQ-010 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: done_id  output  1  index of the requester owning the current result.
REQ-012 SHALL have port: bcd  output  16  {thousands,hundreds,tens,ones} result, registered.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; no other reachable states.
REQ-014 IDLE: when any req is sampled high at a rising edge, SHALL select a winner, load its operand into shift[BIN_W-1:0] with upper bits zero, set the winner's gnt for exactly one cycle, clear the iteration counter, and go to SHIFT.
REQ-015 SHIFT: each cycle SHALL add 3 to every 4-bit BCD nibble >= 5, then shift the whole register left by 1, all in one cycle (double-dabble, one bit per cycle).
REQ-016 SHALL leave SHIFT after exactly BIN_W iterations, load bcd from shift[BIN_W+15:BIN_W], latch done_id, and go to DONE.
REQ-017 DONE: done SHALL be high for exactly one cycle, followed by an unconditional return to IDLE.
REQ-018 Latency: req sampled in cycle T -> gnt in T+1 -> done in T+BIN_W+1 -> next grant no earlier than T+BIN_W+3.
REQ-019 busy SHALL be high in SHIFT and DONE, low in IDLE.
REQ-020 req0/req1 SHALL be ignored outside IDLE; a requester drops req on seeing its gnt; a req still high in IDLE is a new request.
REQ-021 Operands SHALL be captured only at grant; later changes to bin0/bin1 SHALL NOT affect the result in flight.
REQ-022 bcd and done_id SHALL hold their values until the next done.
REQ-023 All four BCD digits SHALL be in range 0..9; bin = 2^BIN_W-1 SHALL convert without loss.

Reset
REQ-024 rst_n low at a rising edge SHALL force IDLE, and set gnt0=gnt1=busy=done=done_id=0, bcd=16'h0000, shift register, counter and arbitration pointer to 0.
REQ-025 Reset asserted mid-conversion SHALL abort it with no done pulse; the first post-reset request SHALL be granted normally.

Configuration
REQ-026 With macro BCD_RR_ARB_EN defined: round-robin arbitration; if both req are high in IDLE, the requester not served last SHALL win; the pointer resets to favour req0.
REQ-027 Without BCD_RR_ARB_EN: fixed priority; req0 SHALL always win over req1; the pointer logic SHALL be absent.

Verification
REQ-028 bin0=12'd4095, req0 pulse in cycle T -> gnt0 in T+1, done in T+13, bcd=16'h4095, done_id=0.
REQ-029 bin1=12'd0, then bin1=12'd9 and bin1=12'd10 -> bcd 16'h0000, 16'h0009, 16'h0010, done_id=1 each.
REQ-030 req0 and req1 high together, bin0=1234, bin1=999, each dropped on its own gnt -> RR build: 16'h1234/id0 then 16'h0999/id1; fixed build: same order.
REQ-031 req0 and req1 held high continuously for 4 conversions -> RR build: ids 0,1,0,1; fixed build: ids 0,0,0,0.
REQ-032 rst_n low for 1 cycle during SHIFT iteration 5 -> no done, bcd=16'h0000, busy=0; a following req0 with bin0=2048 -> bcd=16'h2048.
REQ-033 bin0 changed from 100 to 200 during SHIFT -> bcd=16'h0100.
